sipo_deser: RTL and testbench

//  Parametrised serial-in/parallel-out deserialiser; successor to the single-bit SIPO register.

---
 rtl/sipo_deser_pkg.sv | 28 ++
 rtl/sipo_out_buf.sv | 41 ++++
 rtl/sipo_deser.sv | 177 +++++++++++++++++
 tb/tb_sipo_deser.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sipo_deser_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sipo_deser_pkg
// Description : Shared types and elaboration helpers for the SIPO deserialiser.
// Revision    : 1.0 - initial release
// ============================================================================
package sipo_deser_pkg;

    typedef enum logic [0:0] {
        FILL  = 1'b0,
        STALL = 1'b1
    } deser_state_e;

    function automatic int calc_beats(input int data_bw, input int lanes);
        return (lanes > 0) ? (data_bw / lanes) : 1;
    endfunction

    function automatic int calc_cnt_bw(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

    // Bit positions left unfilled when a word is closed after rcvd beats.
    function automatic int calc_pad_bits(input int beats, input int lanes, input int rcvd);
        return (beats - rcvd) * lanes;
    endfunction

endpackage : sipo_deser_pkg
`default_nettype wire

// File: rtl/sipo_out_buf.sv
`default_nettype none
// ============================================================================
// Module      : sipo_out_buf
// Description : One-entry valid/ready holding register with full-rate drain.
// Revision    : 1.0 - initial release
// ============================================================================
module sipo_out_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             in_valid_i,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             in_ready_o,
    output logic [WIDTH-1:0] out_data_o,
    output logic             out_valid_o,
    input  logic             out_ready_i
);

    logic [WIDTH-1:0] r_data;
    logic             r_valid;

    // Refill allowed in the same cycle the current entry is drained.
    assign in_ready_o  = !r_valid || out_ready_i;
    assign out_data_o  = r_data;
    assign out_valid_o = r_valid;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (in_valid_i && in_ready_o) begin
            r_data  <= in_data_i;
            r_valid <= 1'b1;
        end else if (out_ready_i) begin
            r_valid <= 1'b0;
        end
    end

endmodule : sipo_out_buf
`default_nettype wire

// File: rtl/sipo_deser.sv
`default_nettype none
// ============================================================================
// Module      : sipo_deser
// Description : LANES-wide serial-in / DATA_BW-wide parallel-out deserialiser
//               with one-word output holding register and overrun flag.
//               SIPO_DESER_FLUSH_EN adds flush_i / dout_cnt_o (partial words).
// Revision    : 1.0 - initial release
// ============================================================================
module sipo_deser
    import sipo_deser_pkg::*;
#(
    parameter int DATA_BW   = 8,
    parameter int LANES     = 1,
    parameter int MSB_FIRST = 0
) (
    input  logic                             clk_i,
    input  logic                             reset_n_i,
    input  logic [LANES-1:0]                 serial_data_i,
    input  logic                             wr_en_i,
    output logic                             serial_ready_o,
`ifdef SIPO_DESER_FLUSH_EN
    input  logic                             flush_i,
    output logic [$clog2(DATA_BW/LANES):0]   dout_cnt_o,
`endif
    output logic [DATA_BW-1:0]               dout_bus_o,
    output logic                             dout_valid_o,
    input  logic                             dout_ready_i,
    output logic                             overrun_o
);

    localparam int c_BEATS  = calc_beats(DATA_BW, LANES);
    localparam int c_CNT_BW = calc_cnt_bw(c_BEATS);
    localparam logic [c_CNT_BW-1:0] c_LAST_CNT = c_CNT_BW'(c_BEATS - 1);

    generate
        if ((LANES < 1) || (LANES > DATA_BW) || ((DATA_BW % LANES) != 0)) begin : g_bad_params
            $error("sipo_deser: DATA_BW must be a positive multiple of LANES");
        end
    endgenerate

    deser_state_e        r_state;
    deser_state_e        w_state_nxt;
    logic [c_CNT_BW-1:0] r_cnt;
    logic [DATA_BW-1:0]  r_sr;
    logic [DATA_BW-1:0]  w_sr_shifted;
    logic [DATA_BW-1:0]  w_word;
    logic                r_overrun;
    logic                w_take;
    logic                w_last;
    logic                w_word_done;
    logic                w_push_valid;
    logic                w_buf_ready;

    assign serial_ready_o = (r_state == FILL);
    assign overrun_o      = r_overrun;
    assign w_take         = wr_en_i && serial_ready_o;
    assign w_last         = w_take && (r_cnt == c_LAST_CNT);

    generate
        if (LANES == DATA_BW) begin : g_full_beat
            assign w_sr_shifted = serial_data_i;
        end else if (MSB_FIRST != 0) begin : g_msb_first
            assign w_sr_shifted = {r_sr[DATA_BW-LANES-1:0], serial_data_i};
        end else begin : g_lsb_first
            assign w_sr_shifted = {serial_data_i, r_sr[DATA_BW-1:LANES]};
        end
    endgenerate

`ifdef SIPO_DESER_FLUSH_EN
    localparam int c_OCNT_BW = $clog2(c_BEATS) + 1;
    localparam int c_BUF_W   = DATA_BW + c_OCNT_BW;

    logic [c_OCNT_BW-1:0] w_rcvd;
    logic [c_OCNT_BW-1:0] r_sr_cnt;
    logic [DATA_BW-1:0]   w_cur;
    logic                 w_flush;
    int                   w_pad;

    assign w_rcvd      = c_OCNT_BW'(r_cnt) + c_OCNT_BW'(w_take);
    assign w_cur       = w_take ? w_sr_shifted : r_sr;
    assign w_flush     = flush_i && (r_state == FILL) && ((r_cnt != '0) || w_take);
    assign w_word_done = w_last || w_flush;

    // Shifting the unreceived beats in as zeros also pushes stale bits out.
    always_comb begin
        w_pad  = calc_pad_bits(c_BEATS, LANES, int'(w_rcvd));
        w_word = w_cur;
        if (MSB_FIRST != 0) begin
            w_word = w_cur << w_pad;
        end else begin
            w_word = w_cur >> w_pad;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_sr_cnt <= '0;
        end else if (w_word_done) begin
            r_sr_cnt <= w_rcvd;
        end
    end

    logic [c_BUF_W-1:0] w_push_data;
    logic [c_BUF_W-1:0] w_buf_q;

    assign w_push_data = (r_state == STALL) ? {r_sr_cnt, r_sr} : {w_rcvd, w_word};
    assign dout_bus_o  = w_buf_q[DATA_BW-1:0];
    assign dout_cnt_o  = w_buf_q[c_BUF_W-1:DATA_BW];
`else
    localparam int c_BUF_W = DATA_BW;

    logic [c_BUF_W-1:0] w_push_data;
    logic [c_BUF_W-1:0] w_buf_q;

    assign w_word_done = w_last;
    assign w_word      = w_sr_shifted;
    assign w_push_data = (r_state == STALL) ? r_sr : w_word;
    assign dout_bus_o  = w_buf_q;
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_push_valid = 1'b0;
        unique case (r_state)
            FILL: begin
                w_push_valid = w_word_done;
                if (w_word_done && !w_buf_ready) begin
                    w_state_nxt = STALL;
                end
            end
            STALL: begin
                w_push_valid = 1'b1;
                if (w_buf_ready) begin
                    w_state_nxt = FILL;
                end
            end
            default: w_state_nxt = FILL;
        endcase
    end

    // A completed word that cannot move on stays parked in r_sr (STALL).
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state   <= FILL;
            r_cnt     <= '0;
            r_sr      <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_word_done) begin
                r_cnt <= '0;
                r_sr  <= w_word;
            end else if (w_take) begin
                r_cnt <= r_cnt + 1'b1;
                r_sr  <= w_sr_shifted;
            end
            if (wr_en_i && !serial_ready_o) begin
                r_overrun <= 1'b1;
            end
        end
    end

    sipo_out_buf #(
        .WIDTH (c_BUF_W)
    ) u_out_buf (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .in_valid_i  (w_push_valid),
        .in_data_i   (w_push_data),
        .in_ready_o  (w_buf_ready),
        .out_data_o  (w_buf_q),
        .out_valid_o (dout_valid_o),
        .out_ready_i (dout_ready_i)
    );

endmodule : sipo_deser
`default_nettype wire

// File: tb/tb_sipo_deser.sv
`default_nettype none
// ============================================================================
// Module      : tb_sipo_deser
// Description : Directed bench for sipo_deser with a word-queue reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sipo_deser;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // 8-bit LANES=1 pair (LSB-first and MSB-first share one stream)
    logic [0:0] din = '0;
    logic       wr  = 1'b0;
    logic       rdy = 1'b1;
    logic       ready0, ready1, valid0, valid1, ovr0, ovr1;
    logic [7:0] bus0, bus1;

    // 16-bit LANES=4
    logic [3:0]  d2   = '0;
    logic        wr2  = 1'b0;
    logic        rdy2 = 1'b1;
    logic        ready2, valid2, ovr2;
    logic [15:0] bus2;

`ifdef SIPO_DESER_FLUSH_EN
    logic       fl_off = 1'b0;
    logic [3:0] cnt0, cnt1;
    logic [2:0] cnt2, cnt3;
    logic [1:0] d3   = '0;
    logic       wr3  = 1'b0;
    logic       rdy3 = 1'b1;
    logic       fl3  = 1'b0;
    logic       ready3, valid3, ovr3;
    logic [7:0] bus3;
`endif

    sipo_deser #(.DATA_BW(8), .LANES(1), .MSB_FIRST(0)) u_lsb (
        .clk_i(clk), .reset_n_i(rst_n), .serial_data_i(din), .wr_en_i(wr),
        .serial_ready_o(ready0),
`ifdef SIPO_DESER_FLUSH_EN
        .flush_i(fl_off), .dout_cnt_o(cnt0),
`endif
        .dout_bus_o(bus0), .dout_valid_o(valid0), .dout_ready_i(rdy), .overrun_o(ovr0)
    );

    sipo_deser #(.DATA_BW(8), .LANES(1), .MSB_FIRST(1)) u_msb (
        .clk_i(clk), .reset_n_i(rst_n), .serial_data_i(din), .wr_en_i(wr),
        .serial_ready_o(ready1),
`ifdef SIPO_DESER_FLUSH_EN
        .flush_i(fl_off), .dout_cnt_o(cnt1),
`endif
        .dout_bus_o(bus1), .dout_valid_o(valid1), .dout_ready_i(rdy), .overrun_o(ovr1)
    );

    sipo_deser #(.DATA_BW(16), .LANES(4), .MSB_FIRST(0)) u_w16 (
        .clk_i(clk), .reset_n_i(rst_n), .serial_data_i(d2), .wr_en_i(wr2),
        .serial_ready_o(ready2),
`ifdef SIPO_DESER_FLUSH_EN
        .flush_i(fl_off), .dout_cnt_o(cnt2),
`endif
        .dout_bus_o(bus2), .dout_valid_o(valid2), .dout_ready_i(rdy2), .overrun_o(ovr2)
    );

`ifdef SIPO_DESER_FLUSH_EN
    sipo_deser #(.DATA_BW(8), .LANES(2), .MSB_FIRST(0)) u_fl (
        .clk_i(clk), .reset_n_i(rst_n), .serial_data_i(d3), .wr_en_i(wr3),
        .serial_ready_o(ready3), .flush_i(fl3), .dout_cnt_o(cnt3),
        .dout_bus_o(bus3), .dout_valid_o(valid3), .dout_ready_i(rdy3), .overrun_o(ovr3)
    );
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model for the 8-bit pair: bits gathered in a queue, words
    // formed by plain bit placement, one holding slot plus one parked word.
    bit         m_bits[$];
    bit         m_hold_v, m_pend_v, m_ovr;
    logic [7:0] m_hold_l, m_hold_m, m_pend_l, m_pend_m;

    task automatic model_clear();
        m_bits.delete();
        m_hold_v = 1'b0;
        m_pend_v = 1'b0;
        m_ovr    = 1'b0;
        m_hold_l = 8'h00;
        m_hold_m = 8'h00;
        m_pend_l = 8'h00;
        m_pend_m = 8'h00;
    endtask

    task automatic model_step(input bit w, input bit d, input bit r);
        bit         drain;
        bit         got;
        logic [7:0] wl, wm;
        drain = m_hold_v && r;
        got   = 1'b0;
        wl    = 8'h00;
        wm    = 8'h00;
        if (w && m_pend_v) begin
            m_ovr = 1'b1;
        end else if (w) begin
            m_bits.push_back(d);
            if (m_bits.size() == 8) begin
                for (int i = 0; i < 8; i++) begin
                    wl[i]     = m_bits[i];
                    wm[7 - i] = m_bits[i];
                end
                m_bits.delete();
                got = 1'b1;
            end
        end
        if (m_pend_v) begin
            if (drain) begin
                m_hold_l = m_pend_l;
                m_hold_m = m_pend_m;
                m_pend_v = 1'b0;
            end
        end else if (got) begin
            if (!m_hold_v || drain) begin
                m_hold_l = wl;
                m_hold_m = wm;
                m_hold_v = 1'b1;
            end else begin
                m_pend_l = wl;
                m_pend_m = wm;
                m_pend_v = 1'b1;
            end
        end else if (drain) begin
            m_hold_v = 1'b0;
        end
    endtask

    // Inputs change only just after a rising edge, so at the falling edge they
    // hold exactly what the next rising edge will sample.
    initial begin
        model_clear();
        forever begin
            @(negedge clk);
            if (!rst_n) model_clear();
            check("m_ready_lsb", 32'(ready0), 32'(!m_pend_v));
            check("m_ready_msb", 32'(ready1), 32'(!m_pend_v));
            check("m_valid_lsb", 32'(valid0), 32'(m_hold_v));
            check("m_valid_msb", 32'(valid1), 32'(m_hold_v));
            check("m_bus_lsb",   32'(bus0),   32'(m_hold_l));
            check("m_bus_msb",   32'(bus1),   32'(m_hold_m));
            check("m_ovr_lsb",   32'(ovr0),   32'(m_ovr));
            check("m_ovr_msb",   32'(ovr1),   32'(m_ovr));
            if (rst_n) model_step(wr, din[0], rdy);
        end
    end

    bit beats_a[16] = '{1,0,1,1,0,0,1,0, 0,1,1,0,1,1,1,0};
    bit beats_b[8]  = '{1,1,1,1,0,0,0,0};

    initial begin
        repeat (2) tick();
        check("rst_ready", 32'(ready0), 32'd1);
        check("rst_valid", 32'(valid0), 32'd0);
        check("rst_bus",   32'(bus0),   32'd0);
        check("rst_ovr",   32'(ovr0),   32'd0);
        rst_n = 1'b1;
        tick();

        // Two back-to-back words with the consumer always ready
        for (int i = 0; i < 16; i++) begin
            din = beats_a[i];
            wr  = 1'b1;
            tick();
            if (i == 6) check("w1_not_yet", 32'(valid0), 32'd0);
            if (i == 7) begin
                check("w1_valid",   32'(valid0), 32'd1);
                check("w1_lsb_4D",  32'(bus0),   32'h4D);
                check("w1_msb_B2",  32'(bus1),   32'hB2);
`ifdef SIPO_DESER_FLUSH_EN
                check("w1_cnt",     32'(cnt0),   32'd8);
`endif
            end
            if (i == 15) begin
                check("w2_valid",   32'(valid0), 32'd1);
                check("w2_lsb_76",  32'(bus0),   32'h76);
                check("w2_msb_6E",  32'(bus1),   32'h6E);
            end
        end
        wr = 1'b0;
        repeat (2) tick();

        // Backpressure: one word held, one parked, the rest dropped
        rdy = 1'b0;
        for (int i = 0; i < 24; i++) begin
            din = beats_a[i % 16];
            wr  = 1'b1;
            tick();
            if (i == 14) check("bp_ready_b15", 32'(ready0), 32'd1);
            if (i == 15) begin
                check("bp_ready_b16", 32'(ready0), 32'd0);
                check("bp_ovr_b16",   32'(ovr0),   32'd0);
            end
        end
        wr = 1'b0;
        check("bp_ovr",      32'(ovr0),   32'd1);
        check("bp_hold_4D",  32'(bus0),   32'h4D);
        rdy = 1'b1;
        tick();
        check("bp_next_valid", 32'(valid0), 32'd1);
        check("bp_next_76",    32'(bus0),   32'h76);
        check("bp_ready_back", 32'(ready0), 32'd1);
        tick();
        check("bp_drained",    32'(valid0), 32'd0);

        // Asynchronous reset mid-word with a word waiting
        rdy = 1'b0;
        for (int i = 0; i < 11; i++) begin
            din = beats_a[i];
            wr  = 1'b1;
            tick();
        end
        wr = 1'b0;
        tick();
        check("pre_rst_valid", 32'(valid0), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(valid0), 32'd0);
        check("arst_bus",   32'(bus0),   32'd0);
        check("arst_bus_m", 32'(bus1),   32'd0);
        check("arst_ovr",   32'(ovr0),   32'd0);
        check("arst_ready", 32'(ready0), 32'd1);
        tick();
        rst_n = 1'b1;
        rdy   = 1'b1;
        for (int i = 0; i < 8; i++) begin
            din = beats_b[i];
            wr  = 1'b1;
            tick();
        end
        wr = 1'b0;
        check("post_rst_valid", 32'(valid0), 32'd1);
        check("post_rst_0F",    32'(bus0),   32'h0F);
        check("post_rst_F0",    32'(bus1),   32'hF0);
        tick();

        // 16-bit word from four 4-bit beats
        for (int i = 0; i < 4; i++) begin
            d2  = 4'(4'hA + i);
            wr2 = 1'b1;
            tick();
            if (i == 2) check("w16_not_yet", 32'(valid2), 32'd0);
        end
        wr2 = 1'b0;
        check("w16_valid", 32'(valid2), 32'd1);
        check("w16_DCBA",  32'(bus2),   32'hDCBA);
        check("w16_ready", 32'(ready2), 32'd1);
        tick();
        check("w16_drained", 32'(valid2), 32'd0);
        check("w16_ovr",     32'(ovr2),   32'd0);

`ifdef SIPO_DESER_FLUSH_EN
        // Partial words closed by flush, zero-padded
        d3 = 2'b11; wr3 = 1'b1; tick();
        d3 = 2'b01;             tick();
        wr3 = 1'b0;
        check("fl_not_yet", 32'(valid3), 32'd0);
        fl3 = 1'b1;
        tick();
        fl3 = 1'b0;
        check("fl_valid", 32'(valid3), 32'd1);
        check("fl_07",    32'(bus3),   32'h07);
        check("fl_cnt2",  32'(cnt3),   32'd2);
        tick();
        d3 = 2'b10; wr3 = 1'b1; fl3 = 1'b1;
        tick();
        wr3 = 1'b0;
        check("fl_same_valid", 32'(valid3), 32'd1);
        check("fl_same_02",    32'(bus3),   32'h02);
        check("fl_same_cnt1",  32'(cnt3),   32'd1);
        tick();
        fl3 = 1'b0;
        check("fl_idle_ignored", 32'(valid3), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_sipo_deser
`default_nettype wire
